// File: rtl/display_pkg.sv
// Shared widths, state encoding and the BCD add-3 correction step
// for the credit display path.
package display_pkg;
    localparam int NUM_DIGITS = 4;
    localparam int BCD_W      = 4;
    localparam int VALUE_W    = 10;
    localparam int GLYPH_BASE = 10;
    localparam int BCD_TOT    = NUM_DIGITS * BCD_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CONV = 1'b1
    } conv_state_e;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    function automatic logic [BCD_TOT-1:0] add3(input logic [BCD_TOT-1:0] b);
        logic [BCD_TOT-1:0] r;
        r = b;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b[i*BCD_W +: BCD_W] >= BCD_W'(5))
                r[i*BCD_W +: BCD_W] = b[i*BCD_W +: BCD_W] + BCD_W'(3);
        end
        return r;
    endfunction
endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary to BCD converter, one bit per cycle.
// done/bcd present the finished result during the last CONV cycle.
module bin2bcd_seq
    import display_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [VALUE_W-1:0]   bin,
    output logic                 busy,
    output logic                 done,
    output logic [BCD_TOT-1:0]   bcd
);
    conv_state_e          state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [VALUE_W-1:0]   shift_q, shift_d;
    logic [BCD_TOT-1:0]   bcd_q, bcd_d;
    logic [BCD_TOT-1:0]   adj;
    logic [BCD_TOT-1:0]   step_bcd;
    logic [VALUE_W-1:0]   step_shift;

    assign adj        = add3(bcd_q);
    assign step_bcd   = {adj[BCD_TOT-2:0], shift_q[VALUE_W-1]};
    assign step_shift = {shift_q[VALUE_W-2:0], 1'b0};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        bcd_d   = bcd_q;
        done    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shift_d = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                shift_d = step_shift;
                bcd_d   = step_bcd;
                cnt_d   = cnt_q + 4'd1;
                if (cnt_q == 4'(VALUE_W - 1)) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            bcd_q   <= bcd_d;
        end
    end

    assign busy = (state_q == ST_CONV);
    assign bcd  = step_bcd;
endmodule

// File: rtl/credit_display_scan.sv
// Credit display driver: converts a captured binary credit to BCD and
// time-multiplexes the digits (with leading-zero blanking) onto one code bus.
module credit_display_scan
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [VALUE_W-1:0]      value,
    input  logic                    load,
    input  logic [1:0]              glyph,
    output logic                    busy,
    output logic [BCD_W-1:0]        digit_code,
    output logic [NUM_DIGITS-1:0]   anode_n
);
    localparam int            PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic                   conv_done;
    logic [BCD_TOT-1:0]     conv_bcd;
    logic [BCD_TOT-1:0]     disp_q, disp_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [1:0]             idx_q, idx_d;
    logic [BCD_W-1:0]       code_q, code_d;
    logic [NUM_DIGITS-1:0]  anode_q, anode_d;
    logic                   hi_zero;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .reset (reset),
        .start (load),
        .bin   (value),
        .busy  (busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // All four digits swap together on commit, so the scan never shows a mix.
    assign disp_d = conv_done ? conv_bcd : disp_q;

    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Blank when this digit and everything above it is zero; a live glyph
    // occupies digit 3, so it no longer counts as a leading zero.
    always_comb begin
        hi_zero = 1'b1;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(idx_q) && !(j == NUM_DIGITS - 1 && glyph != 2'd0) &&
                disp_q[j*BCD_W +: BCD_W] != '0)
                hi_zero = 1'b0;
        end
    end

    always_comb begin
        code_d  = disp_q[int'(idx_q)*BCD_W +: BCD_W];
        anode_d = ~(NUM_DIGITS'(1) << idx_q);
        if (idx_q == 2'd3 && glyph != 2'd0) begin
            code_d = BCD_W'(GLYPH_BASE - 1) + BCD_W'(glyph);
        end else if (idx_q != 2'd0 && hi_zero) begin
            code_d  = '0;
            anode_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_q  <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            code_q  <= '0;
            anode_q <= '1;
        end else begin
            disp_q  <= disp_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            code_q  <= code_d;
            anode_q <= anode_d;
        end
    end

    assign digit_code = code_q;
    assign anode_n    = anode_q;
endmodule

// File: tb/tb_credit_display_scan.sv
// Scoreboard bench: a decimal-arithmetic reference model pushes expected
// per-cycle outputs for two scan rates; a monitor pops and compares them.
module tb_credit_display_scan;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] value = '0;
    logic       load = 1'b0;
    logic [1:0] glyph = '0;
    logic       busy0, busy1;
    logic [3:0] code0, code1, an0, an1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       busy;
        logic [3:0] an0, cd0, an1, cd1;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    credit_display_scan #(.REFRESH_DIV(2)) dut0 (
        .clk(clk), .reset(reset), .value(value), .load(load), .glyph(glyph),
        .busy(busy0), .digit_code(code0), .anode_n(an0));

    credit_display_scan #(.REFRESH_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .value(value), .load(load), .glyph(glyph),
        .busy(busy1), .digit_code(code1), .anode_n(an1));

    // Expected {anode_n, code} for scan slot idx showing credit disp.
    function automatic logic [7:0] exp_out(input int idx, input int disp, input int g);
        int p10;
        int shown;
        logic [3:0] an;
        p10 = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
        an  = ~(4'b0001 << idx);
        if (idx == 3 && g != 0) return {an, 4'(9 + g)};
        shown = (g != 0) ? disp % 1000 : disp;
        if (idx != 0 && shown < p10) return {4'b1111, 4'd0};
        return {an, 4'((disp / p10) % 10)};
    endfunction

    // Reference model: conversion is "value appears 10 edges after an
    // accepted load"; scan slot is simply elapsed cycles / div mod 4.
    initial begin : model
        int m_disp, m_pend, m_cnt;
        int m_presc[2];
        int m_idx[2];
        int divs[2];
        logic [7:0] o[2];
        exp_t e;
        divs = '{2, 1};
        m_disp = 0; m_pend = 0; m_cnt = 0;
        m_presc = '{0, 0}; m_idx = '{0, 0};
        o = '{8'hF0, 8'hF0};
        forever begin
            @(posedge clk);
            if (reset) begin
                m_disp = 0; m_cnt = 0;
                for (int d = 0; d < 2; d++) begin
                    m_presc[d] = 0; m_idx[d] = 0; o[d] = 8'hF0;
                end
            end else begin
                for (int d = 0; d < 2; d++) begin
                    o[d] = exp_out(m_idx[d], m_disp, int'(glyph));
                    if (m_presc[d] == divs[d] - 1) begin
                        m_presc[d] = 0;
                        m_idx[d]   = (m_idx[d] + 1) % 4;
                    end else begin
                        m_presc[d]++;
                    end
                end
                if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) m_disp = m_pend;
                end else if (load) begin
                    m_pend = int'(value);
                    m_cnt  = 10;
                end
            end
            e.busy = (m_cnt > 0);
            e.an0 = o[0][7:4]; e.cd0 = o[0][3:0];
            e.an1 = o[1][7:4]; e.cd1 = o[1][3:0];
            exp_q.push_back(e);
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (busy0 !== e.busy || busy1 !== e.busy || an0 !== e.an0 ||
                    code0 !== e.cd0 || an1 !== e.an1 || code1 !== e.cd1) begin
                    n_fail++;
                    $display("FAIL scan t=%0t got busy=%b/%b an0=%b cd0=%0d an1=%b cd1=%0d exp busy=%b an0=%b cd0=%0d an1=%b cd1=%0d",
                             $time, busy0, busy1, an0, code0, an1, code1,
                             e.busy, e.an0, e.cd0, e.an1, e.cd1);
                end
                n_checks++;
                if ($countones(~an0) > 1 || $countones(~an1) > 1) begin
                    n_fail++;
                    $display("FAIL onehot t=%0t got an0=%b an1=%b exp at most one low bit",
                             $time, an0, an1);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_load(input int v);
        value = 10'(v);
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin : stim
        step(3);
        reset = 1'b0;
        step(8);

        // 937 with a stray load of 42 mid-conversion
        do_load(937);
        step(2);
        do_load(42);
        step(20);

        do_load(1000); step(24);
        do_load(1023); step(24);

        glyph = 2'd2;
        do_load(5); step(24);
        glyph = 2'd0;
        step(12);

        // reset lands on the 5th conversion cycle of 500
        do_load(500);
        step(4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        step(10);

        do_load(1234); step(20);

        for (int it = 0; it < 40; it++) begin
            glyph = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            do_load(int'($urandom_range(0, 1023)));
            if ($urandom_range(0, 7) == 0) begin
                step(int'($urandom_range(0, 9)));
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            step(int'($urandom_range(0, 16)));
        end
        glyph = 2'd0;
        step(14);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
